i2c_byte_master: RTL

- Command-driven I2C master bit/byte engine that sits directly upstream of the board's open-drain SDA/SCL pads, between the LC3 I/O-register decode and the bus.
- LC3 issues START, STOP, WRITE-byte and READ-byte commands. The block generates SCL timing and drives SDA through an output-enable, in the same style as the SDAER enables.
- It samples the slave's ACK and read data, and honours slave clock stretching.

---
 rtl/i2c_byte_master.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_byte_master.sv
`default_nettype none
// ============================================================================
// i2c_byte_master : command-driven I2C master bit/byte engine driving
//                   open-drain SDA/SCL enables, with ACK sampling and stretch.
// Revision        : 1.0
// ============================================================================
module i2c_byte_master #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] cmd,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] din,
  input  logic       ack_in,
  output logic [7:0] dout,
  output logic       ack_out,
  output logic       done,
  output logic       busy,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic       scl_i,
  output logic       scl_oe
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_LATCH = 3'd1;
  localparam logic [2:0] c_START = 3'd2;
  localparam logic [2:0] c_WBIT  = 3'd3;
  localparam logic [2:0] c_RBIT  = 3'd4;
  localparam logic [2:0] c_STOP  = 3'd5;
  localparam logic [2:0] c_DONE  = 3'd6;
  localparam logic [2:0] c_ILL   = 3'd7;

  localparam logic [15:0] c_QLAST = 16'(CLK_DIV - 1);

  logic [2:0]  r_state;
  logic [2:0]  r_cmd;
  logic [7:0]  r_din;
  logic        r_ack_in;
  logic [15:0] r_cnt;
  logic [1:0]  r_q;
  logic [3:0]  r_bit;
  logic [7:0]  r_shift;
  logic [7:0]  r_dout;
  logic        r_ack_out;
  logic        r_sda_s;
  logic        r_sda_oe;
  logic        r_scl_oe;

  logic        w_accept;
  logic        w_active;
  logic        w_stall;
  logic        w_qend;
  logic        w_last_bit;
  logic [2:0]  w_cmd_state;
  logic        w_load;
  logic [2:0]  w_lstate;
  logic [1:0]  w_lq;
  logic [3:0]  w_lbit;
  logic        w_scl_n;
  logic        w_sda_n;

  assign w_accept   = cmd_valid & cmd_ready;
  assign w_active   = (r_state == c_START) | (r_state == c_WBIT) |
                      (r_state == c_RBIT)  | (r_state == c_STOP);
  // A released SCL that still reads low is the slave stretching the clock
  assign w_stall    = ~r_scl_oe & ~scl_i;
  assign w_qend     = w_active & ~w_stall & (r_cnt == c_QLAST);
  assign w_last_bit = (r_state == c_START) | (r_state == c_STOP) | (r_bit == 4'd8);

  always_comb begin
    case (r_cmd)
      3'd1:    w_cmd_state = c_START;
      3'd2:    w_cmd_state = c_STOP;
      3'd3:    w_cmd_state = c_WBIT;
      3'd4:    w_cmd_state = c_RBIT;
      default: w_cmd_state = c_ILL;
    endcase
  end

  // Select the quarter whose line levels take effect on this edge
  always_comb begin
    w_load   = 1'b0;
    w_lstate = r_state;
    w_lq     = r_q + 2'd1;
    w_lbit   = r_bit;
    if (r_state == c_LATCH) begin
      w_load   = (w_cmd_state != c_ILL);
      w_lstate = w_cmd_state;
      w_lq     = 2'd0;
      w_lbit   = 4'd0;
    end else if (w_qend) begin
      if (r_q != 2'd3) begin
        w_load = 1'b1;
      end else if (!w_last_bit) begin
        w_load = 1'b1;
        w_lq   = 2'd0;
        w_lbit = r_bit + 4'd1;
      end
    end
  end

  always_comb begin
    w_scl_n = r_scl_oe;
    w_sda_n = r_sda_oe;
    case (w_lstate)
      c_START: begin
        case (w_lq)
          2'd0: w_sda_n = 1'b0;
          2'd1: begin w_scl_n = 1'b0; w_sda_n = 1'b0; end
          2'd2: w_sda_n = 1'b1;
          default: w_scl_n = 1'b1;
        endcase
      end
      c_WBIT: begin
        case (w_lq)
          2'd0: begin
            w_scl_n = 1'b1;
            w_sda_n = (w_lbit == 4'd8) ? 1'b0 : ~r_din[3'd7 - w_lbit[2:0]];
          end
          2'd1: w_scl_n = 1'b0;
          2'd3: w_scl_n = 1'b1;
          default: ;
        endcase
      end
      c_RBIT: begin
        case (w_lq)
          2'd0: begin
            w_scl_n = 1'b1;
            w_sda_n = (w_lbit == 4'd8) ? r_ack_in : 1'b0;
          end
          2'd1: w_scl_n = 1'b0;
          2'd3: w_scl_n = 1'b1;
          default: ;
        endcase
      end
      c_STOP: begin
        case (w_lq)
          2'd0: begin w_scl_n = 1'b1; w_sda_n = 1'b1; end
          2'd1: w_scl_n = 1'b0;
          2'd2: w_sda_n = 1'b0;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_IDLE;
      r_cmd     <= 3'd0;
      r_din     <= 8'h00;
      r_ack_in  <= 1'b0;
      r_cnt     <= 16'd0;
      r_q       <= 2'd0;
      r_bit     <= 4'd0;
      r_shift   <= 8'h00;
      r_dout    <= 8'h00;
      r_ack_out <= 1'b0;
      r_sda_s   <= 1'b1;
      r_sda_oe  <= 1'b0;
      r_scl_oe  <= 1'b0;
    end else begin
      r_sda_s <= (sda_i != 1'b0);
      if (w_load) begin
        r_scl_oe <= w_scl_n;
        r_sda_oe <= w_sda_n;
      end
      case (r_state)
        c_IDLE, c_DONE: begin
          if (w_accept) begin
            r_state  <= c_LATCH;
            r_cmd    <= cmd;
            r_din    <= din;
            r_ack_in <= ack_in;
          end else begin
            r_state <= c_IDLE;
          end
        end
        c_LATCH: begin
          r_state <= w_cmd_state;
          r_cnt   <= 16'd0;
          r_q     <= 2'd0;
          r_bit   <= 4'd0;
        end
        c_ILL: r_state <= c_DONE;
        default: begin
          if (w_qend) begin
            r_cnt <= 16'd0;
            r_q   <= r_q + 2'd1;
            // SDA is sampled at the end of the second SCL-high quarter
            if (r_q == 2'd2) begin
              if (r_state == c_RBIT && r_bit != 4'd8)
                r_shift <= {r_shift[6:0], r_sda_s};
              if (r_state == c_WBIT && r_bit == 4'd8)
                r_ack_out <= ~r_sda_s;
            end
            if (r_q == 2'd3) begin
              if (w_last_bit) begin
                r_state <= c_DONE;
                if (r_state == c_RBIT)
                  r_dout <= r_shift;
              end else begin
                r_bit <= r_bit + 4'd1;
              end
            end
          end else if (!w_stall) begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  assign cmd_ready = (r_state == c_IDLE) | (r_state == c_DONE);
  assign busy      = ~cmd_ready;
  assign done      = (r_state == c_DONE);
  assign dout      = r_dout;
  assign ack_out   = r_ack_out;
  assign sda_oe    = r_sda_oe;
  assign scl_oe    = r_scl_oe;

endmodule
`default_nettype wire
